// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the shift-add sequential multiplier.
// Holds the FSM state encoding and the operand magnitude helper used
// when SEQ_MULT_SIGNED_EN is defined.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Widest operand the helper handles; callers sign-extend into this.
  localparam int MAX_W = 32;

  typedef struct packed {
    logic             neg;
    logic [MAX_W-1:0] mag;
  } abs_t;

  // Magnitude and sign of a sign-extended operand; the most-negative
  // value maps onto itself, which is its correct unsigned magnitude.
  function automatic abs_t abs_w(input logic [MAX_W-1:0] value, input logic tc);
    abs_t r;
    r.neg = tc & value[MAX_W-1];
    r.mag = r.neg ? ((~value) + 32'd1) : value;
    return r;
  endfunction

endpackage

// File: rtl/seq_mult_param_if.sv
// Operand/result bundle between the operand source and the multiplier.
// tc only exists when SEQ_MULT_SIGNED_EN is defined.
// Source must honour busy; consumers sample op when valid pulses.
interface seq_mult_param_if #(parameter int WIDTH = 8);

  logic               load;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
`ifdef SEQ_MULT_SIGNED_EN
  logic               tc;
`endif
  logic [2*WIDTH-1:0] op;
  logic               valid;
  logic               busy;

`ifdef SEQ_MULT_SIGNED_EN
  modport master (output load, a, b, tc, input op, valid, busy);
  modport slave  (input load, a, b, tc, output op, valid, busy);
`else
  modport master (output load, a, b, input op, valid, busy);
  modport slave  (input load, a, b, output op, valid, busy);
`endif

endinterface

// File: rtl/seq_mult_addshift.sv
// One shift-add step: conditional add of mcand into the upper half, then shift right.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when the step is committed.
module seq_mult_addshift #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]   i_mcand,
  input  logic [2*WIDTH:0]   i_acc,
  output logic [2*WIDTH:0]   o_acc
);

  logic [WIDTH-1:0] w_addend;
  logic [WIDTH:0]   w_sum;

  // The accumulator top bit is always zero after a shift, so folding it
  // into the sum costs nothing and keeps the carry exact.
  assign w_addend = i_acc[0] ? i_mcand : '0;
  assign w_sum    = {i_acc[2*WIDTH], i_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
  assign o_acc    = {1'b0, w_sum, i_acc[WIDTH-1:1]};

endmodule

// File: rtl/seq_mult_param.sv
// Shift-add multiplier, one multiplier bit per clock; SEQ_MULT_SIGNED_EN adds two's-complement.
// Latency: load edge to valid rising is WIDTH+1 clocks; one result per WIDTH+2 clocks.
// Backpressure: busy high while working; loads outside IDLE are dropped, not queued.
module seq_mult_param
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  seq_mult_param_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH+1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH-1:0]     r_mcand;
  logic [2*WIDTH:0]     r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic [2*WIDTH-1:0]   r_op;
  logic                 r_valid;
  logic                 r_busy;

  logic                 w_start;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic [2*WIDTH:0]     w_acc_step;
  logic [2*WIDTH-1:0]   w_result;

  assign w_start = (r_state == S_IDLE) && bus.load;

`ifdef SEQ_MULT_SIGNED_EN
  logic r_neg;
  logic w_neg;

  // Run the datapath on magnitudes and restore the sign on the way out.
  assign w_a_mag  = WIDTH'(abs_w(32'($signed(bus.a)), bus.tc));
  assign w_b_mag  = WIDTH'(abs_w(32'($signed(bus.b)), bus.tc));
  assign w_neg    = bus.tc & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
  assign w_result = r_neg ? -r_acc[2*WIDTH-1:0] : r_acc[2*WIDTH-1:0];

  // Result sign is fixed at load time because operands may change afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_neg <= 1'b0;
    end else if (w_start) begin
      r_neg <= w_neg;
    end
  end
`else
  assign w_a_mag  = bus.a;
  assign w_b_mag  = bus.b;
  assign w_result = r_acc[2*WIDTH-1:0];
`endif

  seq_mult_addshift #(.WIDTH(WIDTH)) u_addshift (
    .i_mcand (r_mcand),
    .i_acc   (r_acc),
    .o_acc   (w_acc_step)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: RUN retires WIDTH bits, DONE publishes for one cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_RUN;
      S_RUN:   if (r_cnt == CNT_W'(WIDTH-1)) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, shift-add iterations and result publication.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mcand <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_op    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_mcand <= w_a_mag;
            r_acc   <= {{(WIDTH+1){1'b0}}, w_b_mag};
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          r_acc <= w_acc_step;
          r_cnt <= r_cnt + 1'b1;
        end
        S_DONE: begin
          r_op <= w_result;
        end
        default: ;
      endcase
    end
  end

  // busy spans the valid cycle too, so it covers WIDTH+2 cycles per operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_valid <= (r_state == S_DONE);
      r_busy  <= (w_state_nxt != S_IDLE) || (r_state == S_DONE);
    end
  end

  assign bus.op    = r_op;
  assign bus.valid = r_valid;
  assign bus.busy  = r_busy;

endmodule

// File: tb/tb_seq_mult_param.sv
// Scoreboard bench: 8-bit instance under random and directed loads,
// plus a 16-bit instance for the mid-operation reset and latency case.
// Build with SEQ_MULT_SIGNED_EN to exercise two's-complement mode.
module tb_seq_mult_param;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst8 = 1'b1;
  logic rst16 = 1'b1;
  logic tc8 = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int next_ok = 0;

  typedef struct {
    logic [2*W-1:0] prod;
    int             due;
  } exp_t;
  exp_t q[$];

  seq_mult_param_if #(.WIDTH(8))  if8 ();
  seq_mult_param_if #(.WIDTH(16)) if16 ();

  seq_mult_param #(.WIDTH(8))  u8  (.clk(clk), .reset(rst8),  .bus(if8));
  seq_mult_param #(.WIDTH(16)) u16 (.clk(clk), .reset(rst16), .bus(if16));

  always #5 clk = ~clk;

`ifdef SEQ_MULT_SIGNED_EN
  assign if8.tc  = tc8;
  assign if16.tc = 1'b0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference product: plain integer arithmetic, signed or unsigned per tc.
  function automatic logic [2*W-1:0] model_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic tc);
    longint sa;
    longint sb;
    longint p;
    sa = tc ? longint'($signed(a)) : longint'({56'd0, a});
    sb = tc ? longint'($signed(b)) : longint'({56'd0, b});
    p  = sa * sb;
    return p[2*W-1:0];
  endfunction

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 4))
      0:       v = 8'h00;
      1:       v = 8'hFF;
      2:       v = 8'h80;
      3:       v = 8'h7F;
      default: v = 8'($urandom);
    endcase
    return v;
  endfunction

  // Model: a load edge is accepted once WIDTH+2 edges have passed since the last accepted one.
  initial begin
    exp_t e;
    logic tc_eff;
    forever begin
      @(posedge clk);
      cyc++;
`ifdef SEQ_MULT_SIGNED_EN
      tc_eff = tc8;
`else
      tc_eff = 1'b0;
`endif
      if (!rst8) begin
        next_ok = 0;
      end else if (if8.load && cyc >= next_ok) begin
        e.prod  = model_prod(if8.a, if8.b, tc_eff);
        e.due   = cyc + W + 1;
        q.push_back(e);
        next_ok = cyc + W + 2;
      end
    end
  end

  // Monitor: checks valid timing, op value and busy against the model.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      while (q.size() > 0 && q[0].due < cyc) begin
        e = q.pop_front();
        chk("valid_missing", 64'(cyc), 64'(e.due));
      end
      if (if8.valid) begin
        if (q.size() == 0) begin
          chk("valid_unexpected", 64'(if8.valid), 64'd0);
        end else if (q[0].due != cyc) begin
          chk("valid_early", 64'(cyc), 64'(q[0].due));
        end else begin
          e = q.pop_front();
          chk("op", 64'(if8.op), 64'(e.prod));
        end
      end
      chk("busy", 64'(if8.busy), 64'(cyc < next_ok));
    end
  end

  task automatic start8(input logic [W-1:0] a, input logic [W-1:0] b, input logic tc);
    @(negedge clk);
    if8.load = 1'b1;
    if8.a    = a;
    if8.b    = b;
    tc8      = tc;
    @(negedge clk);
    if8.load = 1'b0;
    if8.a    = 8'($urandom);
    if8.b    = 8'($urandom);
  endtask

  task automatic start16(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    if16.load = 1'b1;
    if16.a    = a;
    if16.b    = b;
    @(negedge clk);
    if16.load = 1'b0;
    if16.a    = 16'($urandom);
    if16.b    = 16'($urandom);
  endtask

  initial begin
    int  lat;
    logic seen;
    if8.load  = 1'b0;
    if8.a     = '0;
    if8.b     = '0;
    if16.load = 1'b0;
    if16.a    = '0;
    if16.b    = '0;
    #1;
    rst8  = 1'b0;
    rst16 = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("reset_op", 64'(if8.op), 64'd0);
      chk("reset_valid16", 64'(if16.valid), 64'd0);
    end
    rst8  = 1'b1;
    rst16 = 1'b1;

    // Largest unsigned operands.
    start8(8'd255, 8'd255, 1'b0);
    repeat (W + 3) @(negedge clk);

    // load held high across two back-to-back operations, both with a zero operand.
    @(negedge clk);
    if8.load = 1'b1;
    if8.a    = 8'd13;
    if8.b    = 8'd0;
    @(negedge clk);
    if8.a    = 8'd0;
    if8.b    = 8'd200;
    repeat (W + 1) @(negedge clk);
    if8.load = 1'b0;
    repeat (W + 3) @(negedge clk);

    // A second load while busy must be dropped.
    start8(8'd7, 8'd6, 1'b0);
    repeat (3) @(negedge clk);
    if8.load = 1'b1;
    if8.a    = 8'd1;
    if8.b    = 8'd1;
    @(negedge clk);
    if8.load = 1'b0;
    repeat (W + 3) @(negedge clk);

`ifdef SEQ_MULT_SIGNED_EN
    start8(8'h80, 8'h80, 1'b1);
    repeat (W + 3) @(negedge clk);
    start8(8'hFB, 8'd7, 1'b1);
    repeat (W + 3) @(negedge clk);
    start8(8'd127, 8'hFF, 1'b1);
    repeat (W + 3) @(negedge clk);
    start8(8'h80, 8'd2, 1'b0);
    repeat (W + 3) @(negedge clk);
`endif

    // Random traffic, including loads while busy and boundary operands.
    repeat (500) begin
      @(negedge clk);
      if8.load = ($urandom_range(0, 2) == 0);
      if8.a    = pick();
      if8.b    = pick();
      tc8      = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    if8.load = 1'b0;
    repeat (2 * W + 6) @(negedge clk);

    // 16-bit instance: reset during RUN aborts cleanly.
    start16(16'd40000, 16'd3);
    repeat (4) @(negedge clk);
    rst16 = 1'b0;
    #1;
    chk("abort_busy", 64'(if16.busy), 64'd0);
    chk("abort_op", 64'(if16.op), 64'd0);
    chk("abort_valid", 64'(if16.valid), 64'd0);
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("abort_no_valid", 64'(if16.valid), 64'd0);
    end
    rst16 = 1'b1;
    start16(16'd40000, 16'd3);
    lat  = 0;
    seen = 1'b0;
    while (lat < 40 && !seen) begin
      @(negedge clk);
      #1;
      lat++;
      seen = if16.valid;
    end
    chk("u16_latency", 64'(lat), 64'd17);
    chk("u16_op", 64'(if16.op), 64'd120000);

    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seq_mult_param.md
# seq_mult_param

Parametrised shift-add sequential multiplier, successor to the fixed 8x8 multiplier in the arithmetic mini-project set. It accepts two WIDTH-bit operands on a load strobe, retires one multiplier bit per clock, and presents a 2*WIDTH-bit product with a one-cycle valid pulse and a busy flag for back-pressure. Optionally, it supports two's-complement operands. It sits between an operand source, which must honour busy, and any result consumer that samples on valid.

## Interface
- WIDTH, 8: operand width in bits. Legal range is 2..32.
- CNT_W, $clog2(WIDTH+1): width of the bit counter. This is a derived localparam and must not be overridden.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset. 0 resets the block.
- load  in  1  start strobe. It is sampled only while busy=0.
- a  in  WIDTH  multiplicand.
- b  in  WIDTH  multiplier.
- tc  in  1  two's-complement mode for the current load. This port exists only with SEQ_MULT_SIGNED_EN.
- op  out  2*WIDTH  product. It holds its value until the next result.
- valid  out  1  one-cycle pulse when op updates.
- busy  out  1  high while a multiplication is in progress.

## Operation
- FSM states:
  - IDLE: entered from reset. load=1 goes to RUN.
  - RUN: stays while count < WIDTH-1, then goes to DONE.
  - DONE: lasts one cycle and always returns to IDLE.
- Load capture in IDLE: on load=1, register a into mcand (WIDTH bits), register b into the low half of acc (2*WIDTH+1 bits), clear the high half, and set count=0.
- Each RUN cycle:
  - If acc[0]=1, add mcand to acc[2W-1:W] with a carry-out.
  - Shift {carry, upper, lower} right by one.
  - Increment count.
- DONE cycle: op <= acc[2W-1:0] and valid=1.
- Unsigned arithmetic is exact. The product always fits in 2*WIDTH bits, so there is no overflow.
- busy=1 in RUN and DONE. load is ignored while busy=1 and is not queued.
- Operands a and b may change freely after the load edge.
- load held high continuously starts a new operation on every IDLE cycle. Back-to-back throughput is one result per WIDTH+2 cycles.
- Reset asserted mid-operation aborts it:
  - The FSM returns to IDLE.
  - op is cleared.
  - valid is not issued.

## Timing
- Reset values: op=0, valid=0, busy=0, state=IDLE, count=0, internal registers 0.
- Load sampled at edge E0. busy rises after E0. RUN occupies edges E1..E_WIDTH.
- The product is registered at edge E_(WIDTH+1). valid is high for exactly the cycle after that edge.
- busy falls after E_(WIDTH+2). The earliest next load edge is E_(WIDTH+2).
- Latency from the load edge to valid rising is WIDTH+1 clocks.
- No combinational path from inputs to outputs. All outputs are registered.

## Configuration
- SEQ_MULT_SIGNED_EN defined:
  - Port tc is present and is captured at load.
  - When tc=1, capture the absolute values of a and b. The most-negative value 2^(WIDTH-1) is represented unsigned in WIDTH bits.
  - Record neg = a[W-1]^b[W-1].
  - Run the unsigned datapath. In DONE, op <= neg ? -acc : acc, computed modulo 2^(2W).
  - When tc=0, behaviour is identical to unsigned mode.
  - Latency is unchanged.
- SEQ_MULT_SIGNED_EN undefined:
  - No tc port and no negation logic.
  - Operands are always unsigned.

## Structure
- Shared package seq_mult_pkg:
  - State enum {S_IDLE, S_RUN, S_DONE}, encoded in 2 bits.
  - Function abs_w(value, tc) returning the magnitude and sign.
- One sub-module, seq_mult_addshift: WIDTH-bit adder with carry-out plus right-shift of the accumulator. It is combinational.
- The FSM, counter and registers stay in the top module.

## Test plan
- WIDTH=8: reset=0 for 3 cycles, then release. Required: op=0, valid=0, busy=0 throughout.
- WIDTH=8, a=255, b=255, load pulse. Required: valid high exactly 9 clocks after the load edge, op=65025, and busy high for 10 cycles.
- WIDTH=8, a=13, b=0, then a=0, b=200, back-to-back with load held high. Required: two valid pulses 10 cycles apart, both with op=0.
- WIDTH=8, load a=7, b=6, then pulse load again with a=1, b=1 while busy. Required: the second load is ignored and op=42 on the single valid pulse.
- WIDTH=16, a=40000, b=3, with reset dropped at RUN cycle 5. Required: no valid pulse, op=0, busy=0 immediately. A new load with a=40000, b=3 gives op=120000 after 17 clocks.
- SEQ_MULT_SIGNED_EN, WIDTH=8, tc=1, four cases:
  - a=-128, b=-128 gives op=16384.
  - a=-5, b=7 gives op=16'hFFDD.
  - a=127, b=-1 gives op=16'hFF81.
  - tc=0 with a=8'h80, b=2 gives op=256.
